// File: rtl/mmss_counter_if.sv
// Control/status bundle for mmss_counter: tick and command inputs, BCD count and flags.
// The alarm_bcd field exists only when MMSS_ALARM_EN is defined.
interface mmss_counter_if;
  logic        tick_in;
  logic        start;
  logic        stop;
  logic        clear;
`ifdef MMSS_ALARM_EN
  logic [15:0] alarm_bcd;
`endif
  logic [15:0] bcd;
  logic        running;
  logic        wrap;
  logic        alarm;

`ifdef MMSS_ALARM_EN
  modport master (output tick_in, start, stop, clear, alarm_bcd,
                  input  bcd, running, wrap, alarm);
  modport slave  (input  tick_in, start, stop, clear, alarm_bcd,
                  output bcd, running, wrap, alarm);
`else
  modport master (output tick_in, start, stop, clear,
                  input  bcd, running, wrap, alarm);
  modport slave  (input  tick_in, start, stop, clear,
                  output bcd, running, wrap, alarm);
`endif
endinterface

// File: rtl/mmss_counter.sv
// BCD mm:ss stopwatch advanced by rising edges of a 1 Hz tick, with start/stop/clear.
// Define MMSS_ALARM_EN to add the sticky alarm comparator against bus.alarm_bcd.
module mmss_counter (
  input  logic          clk,
  input  logic          rst,
  mmss_counter_if.slave bus
);
  typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        tick_q;
  logic [15:0] bcd_q, bcd_d, bcd_inc;
  logic        wrap_q, wrap_d;
  logic        sec_edge;
  logic        step;
  logic [4:0]  carry;

  assign sec_edge = bus.tick_in & ~tick_q;
  assign step     = sec_edge & (state_q == RUNNING) & ~bus.clear;
  assign carry[0] = 1'b1;

  // Digit chain, least significant first: sec_ones, sec_tens, min_ones, min_tens.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      localparam logic [3:0] LIMIT = (gi % 2 == 1) ? 4'd5 : 4'd9;
      logic [3:0] digit;
      logic       at_limit;
      assign digit    = bcd_q[4*gi +: 4];
      assign at_limit = (digit >= LIMIT);
      assign bcd_inc[4*gi +: 4] = !carry[gi] ? digit :
                                  at_limit   ? 4'd0  : digit + 4'd1;
      assign carry[gi+1] = carry[gi] & at_limit;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    wrap_d  = step & carry[4];
    if (bus.stop) begin
      state_d = STOPPED;
    end else if (bus.start) begin
      state_d = RUNNING;
    end
    if (bus.clear) begin
      bcd_d = 16'h0000;
    end else if (step) begin
      bcd_d = bcd_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STOPPED;
      tick_q  <= 1'b0;
      bcd_q   <= 16'h0000;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= bus.tick_in;
      bcd_q   <= bcd_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.bcd     = bcd_q;
  assign bus.running = (state_q == RUNNING);
  assign bus.wrap    = wrap_q;

`ifdef MMSS_ALARM_EN
  // Compare the post-step count one cycle later; clear beats a coincident set.
  logic stepped_q;
  logic alarm_q, alarm_d;

  always_comb begin
    alarm_d = alarm_q;
    if (bus.clear) begin
      alarm_d = 1'b0;
    end else if (stepped_q && (bcd_q == bus.alarm_bcd)) begin
      alarm_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stepped_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      stepped_q <= step;
      alarm_q   <= alarm_d;
    end
  end

  assign bus.alarm = alarm_q;
`else
  assign bus.alarm = 1'b0;
`endif
endmodule

// File: tb/tb_mmss_counter.sv
// Directed self-checking bench for mmss_counter; expected counts come from an
// integer seconds model converted to BCD, independent of the digit chain.
module tb_mmss_counter;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   secs;

  mmss_counter_if bus ();

  mmss_counter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int s);
    int m;
    int ss;
    m  = (s / 60) % 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic tick_rise();
    bus.tick_in = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic tick_fall();
    bus.tick_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic count_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_rise();
      tick_fall();
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus.bcd !== 16'h0000) begin bad++; $display("FAIL reset_bcd got=%h exp=0000", bus.bcd); end
    total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL reset_running got=%b exp=0", bus.running); end
    total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b exp=0", bus.wrap); end
    total++; if (bus.alarm !== 1'b0) begin bad++; $display("FAIL reset_alarm got=%b exp=0", bus.alarm); end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      tick_rise();
      total++; if (bus.bcd !== 16'h0000) begin bad++; $display("FAIL idle_bcd tick=%0d got=%h exp=0000", i, bus.bcd); end
      total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL idle_running tick=%0d got=%b exp=0", i, bus.running); end
      tick_fall();
    end
    $display("test_reset: done, checks=%0d", total);
  endtask

  task automatic test_count();
    pulse_start();
    total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL start_running got=%b exp=1", bus.running); end
    secs = 0;
    for (int i = 0; i < 61; i++) begin
      bus.tick_in = 1'b1;
      #1;
      total++; if (bus.bcd !== to_bcd(secs)) begin bad++; $display("FAIL count_early got=%h exp=%h", bus.bcd, to_bcd(secs)); end
      @(posedge clk); #1;
      secs++;
      total++; if (bus.bcd !== to_bcd(secs)) begin bad++; $display("FAIL count_step got=%h exp=%h", bus.bcd, to_bcd(secs)); end
      tick_fall();
      total++; if (bus.bcd !== to_bcd(secs)) begin bad++; $display("FAIL count_hold got=%h exp=%h", bus.bcd, to_bcd(secs)); end
    end
    total++; if (bus.bcd !== 16'h0101) begin bad++; $display("FAIL count_61 got=%h exp=0101", bus.bcd); end
    $display("test_count: bcd=%h after 61 ticks", bus.bcd);
  endtask

  task automatic test_wrap();
    pulse_clear();
    total++; if (bus.bcd !== 16'h0000) begin bad++; $display("FAIL wrap_clear got=%h exp=0000", bus.bcd); end
    total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL wrap_clear_running got=%b exp=1", bus.running); end
    count_ticks(3598);
    total++; if (bus.bcd !== 16'h5958) begin bad++; $display("FAIL preload got=%h exp=5958", bus.bcd); end
    tick_rise();
    total++; if (bus.bcd !== 16'h5959) begin bad++; $display("FAIL wrap_5959 got=%h exp=5959", bus.bcd); end
    total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL wrap_early got=%b exp=0", bus.wrap); end
    tick_fall();
    tick_rise();
    total++; if (bus.bcd !== 16'h0000) begin bad++; $display("FAIL wrap_0000 got=%h exp=0000", bus.bcd); end
    total++; if (bus.wrap !== 1'b1) begin bad++; $display("FAIL wrap_pulse got=%b exp=1", bus.wrap); end
    tick_fall();
    total++; if (bus.wrap !== 1'b0) begin bad++; $display("FAIL wrap_one_cycle got=%b exp=0", bus.wrap); end
    $display("test_wrap: rollover to %h", bus.bcd);
  endtask

  task automatic test_clear_stop();
    count_ticks(9);
    total++; if (bus.bcd !== 16'h0009) begin bad++; $display("FAIL at_0009 got=%h exp=0009", bus.bcd); end
    bus.tick_in = 1'b1;
    bus.clear   = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    total++; if (bus.bcd !== 16'h0000) begin bad++; $display("FAIL clear_edge got=%h exp=0000", bus.bcd); end
    total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL clear_running got=%b exp=1", bus.running); end
    tick_fall();
    count_ticks(3);
    total++; if (bus.bcd !== 16'h0003) begin bad++; $display("FAIL at_0003 got=%h exp=0003", bus.bcd); end
    bus.tick_in = 1'b1;
    bus.stop    = 1'b1;
    @(posedge clk); #1;
    bus.stop = 1'b0;
    total++; if (bus.bcd !== 16'h0004) begin bad++; $display("FAIL stop_edge got=%h exp=0004", bus.bcd); end
    total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL stop_running got=%b exp=0", bus.running); end
    tick_fall();
    tick_rise();
    total++; if (bus.bcd !== 16'h0004) begin bad++; $display("FAIL stopped_hold got=%h exp=0004", bus.bcd); end
    tick_fall();
    $display("test_clear_stop: bcd=%h running=%b", bus.bcd, bus.running);
  endtask

  task automatic test_start_stop();
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL both_stopped got=%b exp=0", bus.running); end
    bus.tick_in = 1'b1;
    bus.start   = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL start_on_edge_run got=%b exp=1", bus.running); end
    total++; if (bus.bcd !== 16'h0004) begin bad++; $display("FAIL start_on_edge_bcd got=%h exp=0004", bus.bcd); end
    tick_fall();
    tick_rise();
    total++; if (bus.bcd !== 16'h0005) begin bad++; $display("FAIL after_start got=%h exp=0005", bus.bcd); end
    tick_fall();
    pulse_start();
    total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL start_in_run got=%b exp=1", bus.running); end
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL both_running got=%b exp=0", bus.running); end
    $display("test_start_stop: running=%b bcd=%h", bus.running, bus.bcd);
  endtask

  task automatic test_alarm();
    pulse_start();
`ifdef MMSS_ALARM_EN
    bus.alarm_bcd = 16'h0003;
`endif
    pulse_clear();
    total++; if (bus.bcd !== 16'h0000) begin bad++; $display("FAIL alarm_clear got=%h exp=0000", bus.bcd); end
`ifdef MMSS_ALARM_EN
    count_ticks(2);
    tick_rise();
    total++; if (bus.bcd !== 16'h0003) begin bad++; $display("FAIL alarm_bcd3 got=%h exp=0003", bus.bcd); end
    total++; if (bus.alarm !== 1'b0) begin bad++; $display("FAIL alarm_early got=%b exp=0", bus.alarm); end
    tick_fall();
    total++; if (bus.alarm !== 1'b1) begin bad++; $display("FAIL alarm_set got=%b exp=1", bus.alarm); end
    tick_rise();
    tick_fall();
    total++; if (bus.bcd !== 16'h0004) begin bad++; $display("FAIL alarm_bcd4 got=%h exp=0004", bus.bcd); end
    total++; if (bus.alarm !== 1'b1) begin bad++; $display("FAIL alarm_sticky got=%b exp=1", bus.alarm); end
    pulse_clear();
    total++; if (bus.alarm !== 1'b0) begin bad++; $display("FAIL alarm_cleared got=%b exp=0", bus.alarm); end
    count_ticks(2);
    tick_rise();
    bus.tick_in = 1'b0;
    bus.clear   = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    total++; if (bus.alarm !== 1'b0) begin bad++; $display("FAIL alarm_clear_wins got=%b exp=0", bus.alarm); end
`else
    for (int i = 0; i < 4; i++) begin
      tick_rise();
      tick_fall();
      total++; if (bus.alarm !== 1'b0) begin bad++; $display("FAIL alarm_off tick=%0d got=%b exp=0", i, bus.alarm); end
    end
`endif
    $display("test_alarm: alarm=%b bcd=%h", bus.alarm, bus.bcd);
  endtask

  task automatic test_async_reset();
    pulse_clear();
    count_ticks(7);
    total++; if (bus.bcd !== 16'h0007) begin bad++; $display("FAIL pre_rst got=%h exp=0007", bus.bcd); end
    total++; if (bus.running !== 1'b1) begin bad++; $display("FAIL pre_rst_running got=%b exp=1", bus.running); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.bcd !== 16'h0000) begin bad++; $display("FAIL async_rst_bcd got=%h exp=0000", bus.bcd); end
    total++; if (bus.running !== 1'b0) begin bad++; $display("FAIL async_rst_running got=%b exp=0", bus.running); end
    @(posedge clk); #1;
    rst = 1'b0;
    tick_rise();
    total++; if (bus.bcd !== 16'h0000) begin bad++; $display("FAIL post_rst_idle got=%h exp=0000", bus.bcd); end
    tick_fall();
    pulse_start();
    tick_rise();
    total++; if (bus.bcd !== 16'h0001) begin bad++; $display("FAIL post_rst_restart got=%h exp=0001", bus.bcd); end
    tick_fall();
    $display("test_async_reset: bcd=%h", bus.bcd);
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    bus.tick_in = 1'b0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.clear   = 1'b0;
`ifdef MMSS_ALARM_EN
    bus.alarm_bcd = 16'h9999;
`endif
    test_reset();
    test_count();
    test_wrap();
    test_clear_stop();
    test_start_stop();
    test_alarm();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mmss_counter.md
MMSS_COUNTER -- requirements
Module: mmss_counter

Interface
REQ-001 Parameter: none; all widths fixed.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous reset, active-high.
REQ-004 tick_in  input  1  1 Hz square wave from the upstream divider stage, synchronous to clk; each rising edge marks one elapsed second.
REQ-005 start  input  1  one-cycle request to begin counting.
REQ-006 stop  input  1  one-cycle request to halt counting.
REQ-007 clear  input  1  one-cycle request to zero the count.
REQ-008 alarm_bcd  input  16  alarm time {min_tens, min_ones, sec_tens, sec_ones}, 4 bits per digit, BCD (present only with MMSS_ALARM_EN).
REQ-009 bcd  output  16  current count {min_tens, min_ones, sec_tens, sec_ones}, 4 bits per digit, BCD.
REQ-010 running  output  1  high while the FSM is in RUNNING.
REQ-011 wrap  output  1  one-cycle pulse on 59:59 -> 00:00 rollover.
REQ-012 alarm  output  1  sticky alarm flag.

Function
REQ-013 Registered delay tick_q SHALL hold the previous-cycle value of tick_in; sec_edge = tick_in & ~tick_q (combinational).
REQ-014 FSM SHALL have exactly two states: STOPPED, RUNNING.
REQ-015 STOPPED -> RUNNING on start; RUNNING -> STOPPED on stop; start in RUNNING and stop in STOPPED have no effect.
REQ-016 start and stop asserted together: stop wins, next state STOPPED.
REQ-017 A count step SHALL occur at a clock edge where sec_edge=1, the registered state is RUNNING, and clear=0; bcd updates at that edge (1-cycle latency from tick_in rising).
REQ-018 stop in the same cycle as sec_edge: the step still occurs, then state becomes STOPPED.
REQ-019 start in the same cycle as sec_edge while STOPPED: no step for that edge.
REQ-020 Step rules: sec_ones 0-9 and carries into sec_tens 0-5, which carries into min_ones 0-9, which carries into min_tens 0-5; every digit wraps to 0 on carry.
REQ-021 At 59:59 a step yields 00:00 and wrap=1 for exactly that one cycle; wrap=0 otherwise.
REQ-022 clear SHALL force bcd to 16'h0000 at the next edge, regardless of state; FSM state is unchanged; clear has priority over a coincident step.
REQ-023 No digit SHALL ever hold a value outside its range (sec_tens/min_tens <= 5, ones <= 9).
REQ-024 running SHALL be a direct decode of the registered state (no extra latency).

Reset
REQ-025 rst high SHALL immediately force: state STOPPED, bcd=16'h0000, tick_q=0, wrap=0, alarm=0.
REQ-026 rst asserted mid-count SHALL abandon the count with no partial update; after release, counting resumes only after a new start.

Configuration
REQ-027 Macro MMSS_ALARM_EN: when defined, alarm SHALL set at the edge following a step whose resulting bcd equals alarm_bcd, SHALL stay high until clear or rst, and a clear coincident with setting SHALL win.
REQ-028 MMSS_ALARM_EN undefined: alarm_bcd port absent, alarm tied 0, no comparator logic.

Verification
REQ-029 rst pulse, then 5 tick_in rising edges with no start -> bcd stays 16'h0000, running=0.
REQ-030 start, then 61 tick_in rising edges -> bcd=16'h0101 (01:01); each update lands one clk after its tick_in rise.
REQ-031 Preload by counting to 59:58, then 2 edges -> bcd 16'h5959 then 16'h0000 with wrap high for exactly one cycle.
REQ-032 clear coincident with sec_edge at 00:09 -> bcd=16'h0000 (no step to 00:10), running stays 1; stop coincident with sec_edge at 00:03 -> bcd=16'h0004, running=0.
REQ-033 MMSS_ALARM_EN defined, alarm_bcd=16'h0003, run 3 edges -> alarm rises one cycle after bcd=16'h0003, stays high past 00:04, drops on clear; undefined build -> alarm=0 throughout.
REQ-034 rst asserted asynchronously between clk edges at 00:07 while RUNNING -> bcd=16'h0000 and running=0 before the next clk edge.
